// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider / tick generator with glitch-free divisor changes.
// Optional feature macro: CLKDIV_SYNC_EN adds sync_i, which re-phases every running channel.
module clk_div_gen #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int RST_DIV = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         en_i,
    input  logic                      div_wr_i,
    input  logic [$clog2(NUM_CH)-1:0] div_ch_i,
    input  logic [CNT_W-1:0]          div_i,
`ifdef CLKDIV_SYNC_EN
    input  logic                      sync_i,
`endif
    output logic [NUM_CH-1:0]         clk_o,
    output logic [NUM_CH-1:0]         tick_o,
    output logic [NUM_CH-1:0]         active_o,
    output logic [NUM_CH-1:0]         pend_o
);

    logic [CNT_W-1:0]  per_q     [NUM_CH];
    logic [CNT_W-1:0]  per_d     [NUM_CH];
    logic [CNT_W-1:0]  cnt_q     [NUM_CH];
    logic [CNT_W-1:0]  cnt_d     [NUM_CH];
    logic [CNT_W-1:0]  pendVal_q [NUM_CH];
    logic [CNT_W-1:0]  pendVal_d [NUM_CH];
    logic [NUM_CH-1:0] run_q, run_d;
    logic [NUM_CH-1:0] pendVld_q, pendVld_d;
    logic [NUM_CH-1:0] clk_q, clk_d;
    logic [NUM_CH-1:0] tick_q, tick_d;

    logic [NUM_CH-1:0] wrHit;
    logic [NUM_CH-1:0] boundary;
    logic [NUM_CH-1:0] restart;
    logic [CNT_W-1:0]  divClamped;

    // Periods below 2 cannot produce both a low and a high phase.
    assign divClamped = (div_i < CNT_W'(2)) ? CNT_W'(2) : div_i;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wrHit[i]    = div_wr_i && (int'(div_ch_i) == i);
            boundary[i] = run_q[i] && (cnt_q[i] == per_q[i] - CNT_W'(1));
`ifdef CLKDIV_SYNC_EN
            restart[i]  = boundary[i] || (sync_i && run_q[i]);
`else
            restart[i]  = boundary[i];
`endif
        end
    end

    always_comb begin
        per_d     = per_q;
        cnt_d     = cnt_q;
        pendVal_d = pendVal_q;
        run_d     = run_q;
        pendVld_d = pendVld_q;
        clk_d     = '0;
        tick_d    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!run_q[i]) begin
                cnt_d[i] = '0;
                run_d[i] = en_i[i];
                if (wrHit[i]) begin
                    per_d[i] = divClamped;
                end
            end else if (restart[i]) begin
                // A write on the restart cycle itself is held for the period after this one.
                cnt_d[i] = '0;
                run_d[i] = en_i[i];
                if (pendVld_q[i]) begin
                    per_d[i]     = pendVal_q[i];
                    pendVld_d[i] = 1'b0;
                end
                if (wrHit[i]) begin
                    pendVal_d[i] = divClamped;
                    pendVld_d[i] = 1'b1;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
                if (wrHit[i]) begin
                    pendVal_d[i] = divClamped;
                    pendVld_d[i] = 1'b1;
                end
            end
            clk_d[i]  = run_d[i] && (cnt_d[i] >= per_d[i] - (per_d[i] >> 1));
            tick_d[i] = run_d[i] && (cnt_d[i] == per_d[i] - CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                per_q[i]     <= CNT_W'(RST_DIV);
                cnt_q[i]     <= '0;
                pendVal_q[i] <= '0;
            end
            run_q     <= '0;
            pendVld_q <= '0;
            clk_q     <= '0;
            tick_q    <= '0;
        end else begin
            per_q     <= per_d;
            cnt_q     <= cnt_d;
            pendVal_q <= pendVal_d;
            run_q     <= run_d;
            pendVld_q <= pendVld_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_o    = clk_q;
    assign tick_o   = tick_q;
    assign active_o = run_q;
    assign pend_o   = pendVld_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: phase-arithmetic reference model plus directed literal checks.
// Exercises the sync_i path only when CLKDIV_SYNC_EN is defined.
module tb_clk_div_gen;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 16;
    localparam int RST_DIV = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] en_i;
    logic              div_wr_i;
    logic [1:0]        div_ch_i;
    logic [CNT_W-1:0]  div_i;
    logic              sync_i;
    logic [NUM_CH-1:0] clk_o, tick_o, active_o, pend_o;

    int total = 0;
    int bad   = 0;

    clk_div_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RST_DIV(RST_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en_i),
        .div_wr_i (div_wr_i),
        .div_ch_i (div_ch_i),
        .div_i    (div_i),
`ifdef CLKDIV_SYNC_EN
        .sync_i   (sync_i),
`endif
        .clk_o    (clk_o),
        .tick_o   (tick_o),
        .active_o (active_o),
        .pend_o   (pend_o)
    );

    always #5 clk = ~clk;

    // Reference model: a channel's phase is the cycle distance from its last restart, modulo its period.
    int   nowT = 0;
    logic modelValid = 1'b0;
    logic mRun     [NUM_CH];
    int   mPer     [NUM_CH];
    int   mStart   [NUM_CH];
    int   mPendVal [NUM_CH];
    logic mPendVld [NUM_CH];

    function automatic int phaseOf(input int c);
        return (nowT - mStart[c]) % mPer[c];
    endfunction

    initial forever begin
        @(posedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
            int   ph;
            int   clampVal;
            logic hit;
            logic atEnd;
            if (rst) begin
                mRun[c] = 1'b0; mPer[c] = RST_DIV; mPendVld[c] = 1'b0;
                mPendVal[c] = 0; mStart[c] = 0;
                modelValid = 1'b1;
            end else if (modelValid) begin
                ph       = phaseOf(c);
                hit      = div_wr_i && (int'(div_ch_i) == c);
                clampVal = (int'(div_i) < 2) ? 2 : int'(div_i);
                atEnd    = mRun[c] && (ph == mPer[c] - 1);
`ifdef CLKDIV_SYNC_EN
                atEnd    = atEnd || (mRun[c] && sync_i);
`endif
                if (!mRun[c]) begin
                    if (hit) mPer[c] = clampVal;
                    if (en_i[c]) begin
                        mRun[c] = 1'b1;
                        mStart[c] = nowT + 1;
                    end
                end else if (atEnd) begin
                    if (mPendVld[c]) begin
                        mPer[c] = mPendVal[c];
                        mPendVld[c] = 1'b0;
                    end
                    mRun[c] = en_i[c];
                    mStart[c] = nowT + 1;
                    if (hit) begin
                        mPendVal[c] = clampVal;
                        mPendVld[c] = 1'b1;
                    end
                end else if (hit) begin
                    mPendVal[c] = clampVal;
                    mPendVld[c] = 1'b1;
                end
            end
        end
        nowT++;
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // High phase is the last floor(per/2) cycles, i.e. phase*2 >= per.
    initial forever begin
        logic [NUM_CH-1:0] eClk, eTick, eAct, ePend;
        @(negedge clk);
        if (modelValid) begin
            for (int c = 0; c < NUM_CH; c++) begin
                int ph;
                ph       = phaseOf(c);
                eClk[c]  = mRun[c] && (ph * 2 >= mPer[c]);
                eTick[c] = mRun[c] && (ph == mPer[c] - 1);
                eAct[c]  = mRun[c];
                ePend[c] = mPendVld[c];
            end
            checkOutput("model_clk",    16'(clk_o),    16'(eClk));
            checkOutput("model_tick",   16'(tick_o),   16'(eTick));
            checkOutput("model_active", 16'(active_o), 16'(eAct));
            checkOutput("model_pend",   16'(pend_o),   16'(ePend));
        end
    end

    task automatic applyStimulus(input logic [3:0] en, input logic wr, input logic [1:0] ch,
                                 input logic [15:0] dv);
        en_i = en; div_wr_i = wr; div_ch_i = ch; div_i = dv;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_clk"},    16'(clk_o),    16'h0);
        checkOutput({name, "_tick"},   16'(tick_o),   16'h0);
        checkOutput({name, "_active"}, 16'(active_o), 16'h0);
        checkOutput({name, "_pend"},   16'(pend_o),   16'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic expClk4  [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
        logic expTick4 [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        rst = 1'b1; sync_i = 1'b0;
        applyStimulus(4'b0000, 1'b0, 2'd0, 16'd0);
        nextCycle(); nextCycle();
        rst = 1'b0;
        checkAllZero("reset");

        // ch0 at the reset period of 4
        applyStimulus(4'b0001, 1'b0, 2'd0, 16'd0);
        for (int i = 0; i < 8; i++) begin
            nextCycle();
            checkOutput("ch0_per4_clk",  16'(clk_o),  16'(expClk4[i]));
            checkOutput("ch0_per4_tick", 16'(tick_o), 16'(expTick4[i]));
        end

        // ch1: period 6, then 3 written mid-period
        applyStimulus(4'b0001, 1'b1, 2'd1, 16'd6); nextCycle();
        applyStimulus(4'b0011, 1'b0, 2'd0, 16'd0); nextCycle();
        checkOutput("ch1_start_active", 16'(active_o[1]), 16'd1);
        checkOutput("ch1_start_clk",    16'(clk_o[1]),    16'd0);
        nextCycle();
        applyStimulus(4'b0011, 1'b1, 2'd1, 16'd3); nextCycle();
        checkOutput("ch1_pend_set", 16'(pend_o[1]), 16'd1);
        applyStimulus(4'b0011, 1'b0, 2'd0, 16'd0);
        nextCycle();
        checkOutput("ch1_cnt3_clk", 16'(clk_o[1]), 16'd1);
        nextCycle(); nextCycle();
        checkOutput("ch1_old_tick", 16'(tick_o[1]), 16'd1);
        checkOutput("ch1_pend_hold", 16'(pend_o[1]), 16'd1);
        nextCycle();
        checkOutput("ch1_pend_clr", 16'(pend_o[1]), 16'd0);
        checkOutput("ch1_new_clk0", 16'(clk_o[1]),  16'd0);
        nextCycle();
        checkOutput("ch1_new_clk1", 16'(clk_o[1]),  16'd0);
        nextCycle();
        checkOutput("ch1_new_clk2", 16'(clk_o[1]),  16'd1);
        checkOutput("ch1_new_tick", 16'(tick_o[1]), 16'd1);
        nextCycle();
        checkOutput("ch1_new_tick_end", 16'(tick_o[1]), 16'd0);

        // ch2: divisors 0 and 1 both clamp to 2
        applyStimulus(4'b0011, 1'b1, 2'd2, 16'd0); nextCycle();
        applyStimulus(4'b0011, 1'b1, 2'd2, 16'd1); nextCycle();
        applyStimulus(4'b0111, 1'b0, 2'd0, 16'd0); nextCycle();
        checkOutput("ch2_start_clk", 16'(clk_o[2]), 16'd0);
        for (int k = 0; k < 6; k++) begin
            nextCycle();
            checkOutput("ch2_per2_clk",  16'(clk_o[2]),  16'((k % 2) == 0));
            checkOutput("ch2_per2_tick", 16'(tick_o[2]), 16'((k % 2) == 0));
        end

        applyStimulus(4'b0000, 1'b0, 2'd0, 16'd0);
        rst = 1'b1; nextCycle(); rst = 1'b0;
        checkAllZero("reset_run");

        // ch0 period 5: en glitch mid-period is ignored, then a real stop
        applyStimulus(4'b0000, 1'b1, 2'd0, 16'd5); nextCycle();
        applyStimulus(4'b0001, 1'b0, 2'd0, 16'd0); nextCycle(); nextCycle();
        applyStimulus(4'b0000, 1'b0, 2'd0, 16'd0); nextCycle();
        checkOutput("ch0_glitch_active", 16'(active_o[0]), 16'd1);
        nextCycle();
        checkOutput("ch0_cnt3_clk", 16'(clk_o[0]), 16'd1);
        applyStimulus(4'b0001, 1'b0, 2'd0, 16'd0); nextCycle();
        checkOutput("ch0_per5_tick", 16'(tick_o[0]), 16'd1);
        nextCycle();
        checkOutput("ch0_no_stop", 16'(active_o[0]), 16'd1);
        nextCycle();
        applyStimulus(4'b0000, 1'b0, 2'd0, 16'd0);
        nextCycle(); nextCycle(); nextCycle();
        checkOutput("ch0_last_tick",   16'(tick_o[0]),   16'd1);
        checkOutput("ch0_last_active", 16'(active_o[0]), 16'd1);
        nextCycle();
        checkOutput("ch0_stop_active", 16'(active_o[0]), 16'd0);
        checkOutput("ch0_stop_clk",    16'(clk_o[0]),    16'd0);
        nextCycle();
        checkOutput("ch0_idle_clk", 16'(clk_o[0]), 16'd0);

        // ch3 period 8 with a pending write, reset mid-period
        applyStimulus(4'b0000, 1'b1, 2'd3, 16'd8); nextCycle();
        applyStimulus(4'b1000, 1'b0, 2'd0, 16'd0); nextCycle();
        applyStimulus(4'b1000, 1'b1, 2'd3, 16'd3); nextCycle();
        applyStimulus(4'b1000, 1'b0, 2'd0, 16'd0); nextCycle();
        checkOutput("ch3_pend", 16'(pend_o[3]), 16'd1);
        rst = 1'b1; nextCycle();
        checkAllZero("reset_pend");
        rst = 1'b0; nextCycle(); nextCycle(); nextCycle();
        checkOutput("ch3_rstdiv_clk", 16'(clk_o[3]), 16'd1);
        nextCycle();
        checkOutput("ch3_rstdiv_tick", 16'(tick_o[3]), 16'd1);

`ifdef CLKDIV_SYNC_EN
        applyStimulus(4'b0000, 1'b0, 2'd0, 16'd0);
        rst = 1'b1; nextCycle(); rst = 1'b0;
        applyStimulus(4'b0000, 1'b1, 2'd1, 16'd8); nextCycle();
        applyStimulus(4'b0001, 1'b0, 2'd0, 16'd0);
        nextCycle(); nextCycle(); nextCycle();
        applyStimulus(4'b0011, 1'b0, 2'd0, 16'd0);
        repeat (5) nextCycle();
        sync_i = 1'b1; nextCycle(); sync_i = 1'b0;
        checkOutput("sync_clk",    16'(clk_o),    16'h0);
        checkOutput("sync_tick",   16'(tick_o),   16'h0);
        checkOutput("sync_active", 16'(active_o), 16'h3);
        for (int k = 1; k <= 16; k++) begin
            nextCycle();
            checkOutput("sync_tick0", 16'(tick_o[0]), 16'((k % 4) == 3));
            checkOutput("sync_tick1", 16'(tick_o[1]), 16'((k % 8) == 7));
        end
`endif

        nextCycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Parametrised multi-channel clock divider and tick generator for the MCU clock tree. It generalises the fixed divide-by-2 toggle divider into NUM_CH independent channels. Each channel has a runtime-programmable period, glitch-free divisor changes, clean start/stop, and a one-cycle tick per period. It sits in `soc_top` after the board clock and feeds divided clocks and enables to the core and peripherals (SPI, UART baud, GPIO debounce).

## Interface
- `NUM_CH`, 4: number of independent divider channels.
- `CNT_W`, 16: width of period and counter; max period 2^CNT_W-1.
- `RST_DIV`, 4: period loaded into every channel at reset; must be ≥2.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `en_i`  in  NUM_CH  per-channel run request, sampled only when the channel is idle or at a period boundary.
- `div_wr_i`  in  1  divisor write strobe, one cycle.
- `div_ch_i`  in  $clog2(NUM_CH)  target channel of write; ≥NUM_CH ignored.
- `div_i`  in  CNT_W  new period in `clk` cycles; values 0 and 1 are clamped to 2.
- `sync_i`  in  1  phase-align strobe (only with `CLKDIV_SYNC_EN`).
- `clk_o`  out  NUM_CH  divided clock, flop-driven.
- `tick_o`  out  NUM_CH  one-cycle pulse on the last cycle of each period, flop-driven.
- `active_o`  out  NUM_CH  channel running.
- `pend_o`  out  NUM_CH  divisor write waiting for the next boundary.

## Operation
- Per-channel state:
  - `per`: active period.
  - `cnt`: 0..per-1.
  - `run`.
  - `pend_val`, `pend_vld`.
- Two states per channel:
  - IDLE (`run`=0): `cnt` held at 0.
  - RUN (`run`=1): `cnt` increments and wraps at `per`-1.
- Boundary: `run`=1 and `cnt`==`per`-1.
- Transitions:
  - IDLE and `en_i`=1 → RUN with `cnt`=0.
  - At a boundary, `run`<=`en_i`, so `en_i`=0 → IDLE.
  - `en_i` is ignored mid-period. Stop always completes the current period, so there are no runt pulses.
- Divisor writes:
  - Channel IDLE: `per`<=clamp(`div_i`) next cycle; `pend_vld` stays 0.
  - Channel RUN: `pend_val`<=clamp(`div_i`), `pend_vld`<=1.
  - A second write before the boundary overwrites `pend_val`.
  - At a boundary with `pend_vld`=1: `per`<=`pend_val`, `pend_vld`<=0.
  - A write landing on the boundary cycle is captured as pending and applies at the following boundary.
- Decode, using the registered state:
  - `clk_o` = `run` && (`cnt` ≥ `per` − floor(`per`/2)). The low phase is the longer one for odd periods; the output starts low.
  - `tick_o` = `run` && `cnt`==`per`-1.
  - Both outputs are registered from next-state values so they align with `cnt`/`per`.
- `active_o`=`run`; `pend_o`=`pend_vld`.

## Timing
- Reset values:
  - `cnt`=0, `per`=RST_DIV, `run`=0, `pend_vld`=0.
  - `clk_o`=0, `tick_o`=0, `active_o`=0, `pend_o`=0.
- Start latency: `en_i` high at edge N gives `active_o`=1 after N.
  - `clk_o` first rises after edge N + (`per` − floor(`per`/2)).
  - First `tick_o` follows edge N+`per`-1.
- Period of `clk_o` and of `tick_o` = `per` cycles exactly.
  - Period 2 gives a 50% clock and a tick every other cycle.
- Stop: `clk_o` ends low and `active_o` falls at the edge following the boundary cycle.
- `rst` mid-period: all channels return to IDLE at the next edge, `clk_o` low, pending writes discarded.
- Counter arithmetic is CNT_W-bit unsigned. `cnt` never exceeds `per`-1, so no overflow.

## Configuration
- `CLKDIV_SYNC_EN` defined:
  - The `sync_i` port exists.
  - `sync_i`=1 at an edge forces every RUN channel to `cnt`<=0, `clk_o`<=0, `tick_o`<=0.
  - It applies pending divisors and samples `en_i` exactly as a boundary does. It takes priority over a natural boundary in the same cycle.
  - IDLE channels are unaffected.
- `CLKDIV_SYNC_EN` undefined: no `sync_i` port; channels run free-phase.

## Test plan
- Reset then `en_i`=4'b0001, RST_DIV=4 → ch0: `clk_o` 0,0,1,1 repeating; `tick_o` every 4th cycle; other channels stay 0.
- Ch1 running at `per`=6, write `div_i`=3 mid-period → `pend_o[1]`=1. The current 6-cycle period completes. After that the `clk_o` pattern is 0,0,1 with ticks every 3 cycles, and `pend_o[1]` clears.
- Write `div_i`=0 and then `div_i`=1 to idle ch2, enable it → both clamp to 2; `clk_o` toggles every cycle.
- Ch0 at `per`=5, drop `en_i` at `cnt`=1 and re-raise it at `cnt`=3 → no stop. Drop `en_i` through the boundary → `active_o` falls after the tick and `clk_o` stays low.
- Assert `rst` at `cnt`=2 of a `per`=8 channel with a pending write → next cycle all outputs 0, `per`=RST_DIV, `pend_o`=0.
- With `CLKDIV_SYNC_EN`: ch0 `per`=4 and ch1 `per`=8 at arbitrary phases, pulse `sync_i` → both restart at `cnt`=0. After that, every second ch0 tick coincides with a ch1 tick.
